// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant held for the whole bus_busy
// tenure, with a watchdog that revokes a grant that never starts or never finishes.
module bus_arbiter #(
    parameter int NUM_REQ   = 6,
    parameter int ID_WIDTH  = 3,
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_REQ-1:0]  bus_req,
    input  logic                bus_busy,
    output logic [NUM_REQ-1:0]  bus_grant,
    output logic                grant_valid,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

    state_t                r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic                  r_valid;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic                  r_timeout_err;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [ID_WIDTH-1:0]   r_last;

    logic                  w_pick_found;
    logic [ID_WIDTH-1:0]   w_pick_id;
    logic                  w_owner_req;
    logic                  w_cnt_expired;

    // First requester strictly above last wins; otherwise the lowest requester (wrap).
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [NUM_REQ-1:0]  req,
        input logic [ID_WIDTH-1:0] last
    );
        logic                found_hi;
        logic                found_lo;
        logic [ID_WIDTH-1:0] win_hi;
        logic [ID_WIDTH-1:0] win_lo;
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = {ID_WIDTH{1'b0}};
        win_lo   = {ID_WIDTH{1'b0}};
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found_hi && req[j] && (ID_WIDTH'(j) > last)) begin
                found_hi = 1'b1;
                win_hi   = ID_WIDTH'(j);
            end else begin
                found_hi = found_hi;
            end
            if (!found_lo && req[j]) begin
                found_lo = 1'b1;
                win_lo   = ID_WIDTH'(j);
            end else begin
                found_lo = found_lo;
            end
        end
        if (found_hi) begin
            return {1'b1, win_hi};
        end else begin
            return {found_lo, win_lo};
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [ID_WIDTH-1:0] idx);
        logic [NUM_REQ-1:0] v;
        for (int j = 0; j < NUM_REQ; j++) begin
            v[j] = (ID_WIDTH'(j) == idx);
        end
        return v;
    endfunction

    // Arbitration winner and tenure status decode.
    always_comb begin
        {w_pick_found, w_pick_id} = rr_pick(bus_req, r_last);
        w_owner_req   = |(bus_req & r_grant);
        w_cnt_expired = (r_cnt == TO_LAST);
    end

    // Tenure FSM with registered grant, id, watchdog counter and rotation pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= {NUM_REQ{1'b0}};
            r_valid       <= 1'b0;
            r_grant_id    <= {ID_WIDTH{1'b0}};
            r_timeout_err <= 1'b0;
            r_cnt         <= {CNT_WIDTH{1'b0}};
            r_last        <= LAST_INIT;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!bus_busy && w_pick_found) begin
                        r_state    <= ST_GRANT;
                        r_grant    <= to_onehot(w_pick_id);
                        r_valid    <= 1'b1;
                        r_grant_id <= w_pick_id;
                        r_cnt      <= {CNT_WIDTH{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                // bus_busy outranks both an abandoned request and the watchdog.
                ST_GRANT: begin
                    if (bus_busy) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= {CNT_WIDTH{1'b0}};
                    end else if (!w_owner_req || w_cnt_expired) begin
                        r_state       <= ST_RELEASE;
                        r_grant       <= {NUM_REQ{1'b0}};
                        r_valid       <= 1'b0;
                        r_last        <= r_grant_id;
                        r_timeout_err <= w_owner_req;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_BUSY: begin
                    if (!bus_busy || w_cnt_expired) begin
                        r_state       <= ST_RELEASE;
                        r_grant       <= {NUM_REQ{1'b0}};
                        r_valid       <= 1'b0;
                        r_last        <= r_grant_id;
                        r_timeout_err <= bus_busy;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= {NUM_REQ{1'b0}};
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus_grant   = r_grant;
    assign grant_valid = r_valid;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (TIMEOUT=4) with hand-computed expectations.
module tb_bus_arbiter;

    logic       clk;
    logic       reset_n;
    logic [5:0] bus_req;
    logic       bus_busy;
    logic [5:0] bus_grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       timeout_err;

    int errors;
    int checks;

    bus_arbiter #(
        .NUM_REQ   (6),
        .ID_WIDTH  (3),
        .TIMEOUT   (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_req     (bus_req),
        .bus_busy    (bus_busy),
        .bus_grant   (bus_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [5:0] g, input logic [2:0] id);
        chk({tag, "_grant"}, 32'(bus_grant), 32'(g));
        chk({tag, "_valid"}, 32'(grant_valid), 32'(|g));
        chk({tag, "_id"}, 32'(grant_id), 32'(id));
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset_n  = 1'b0;
        bus_req  = 6'b111111;
        bus_busy = 1'b0;

        // Reset with all masters requesting
        tick(); tick(); tick();
        chk_grant("reset", 6'b000000, 3'd0);
        chk("reset_terr", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        tick();
        chk_grant("first", 6'b000001, 3'd0);

        // Rotation: each owner busy for 2 cycles, two dead cycles between grants
        for (int k = 1; k <= 6; k++) begin
            bus_busy = 1'b1;
            tick(); tick();
            bus_busy = 1'b0;
            tick();
            chk("rot_gap1", 32'(grant_valid), 32'd0);
            tick();
            chk("rot_gap2", 32'(bus_grant), 32'd0);
            tick();
            chk("rot_grant", 32'(bus_grant), 32'(6'b000001 << (k % 6)));
            chk("rot_id", 32'(grant_id), 32'(k % 6));
        end

        // Abandon master 0, then busy blocks arbitration in IDLE
        bus_req = 6'b000000;
        tick();
        chk("aband0_terr", 32'(timeout_err), 32'd0);
        chk("aband0_grant", 32'(bus_grant), 32'd0);
        tick();
        bus_busy = 1'b1;
        bus_req  = 6'b001000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("busyblk", 32'(bus_grant), 32'd0);
        end
        bus_busy = 1'b0;
        tick();
        chk_grant("busyblk_after", 6'b001000, 3'd3);

        // Watchdog in GRANT: master 3 never starts
        tick(); tick(); tick();
        chk("gto_hold", 32'(bus_grant), 32'(6'b001000));
        chk("gto_noerr", 32'(timeout_err), 32'd0);
        tick();
        chk("gto_drop", 32'(bus_grant), 32'd0);
        chk("gto_err", 32'(timeout_err), 32'd1);
        bus_req = 6'b001100;
        tick();
        chk("gto_errpulse", 32'(timeout_err), 32'd0);

        // Watchdog in BUSY: master 2 holds busy
        tick();
        chk_grant("bto_grant", 6'b000100, 3'd2);
        bus_busy = 1'b1;
        tick(); tick(); tick(); tick();
        chk("bto_hold", 32'(bus_grant), 32'(6'b000100));
        chk("bto_noerr", 32'(timeout_err), 32'd0);
        tick();
        chk("bto_drop", 32'(bus_grant), 32'd0);
        chk("bto_err", 32'(timeout_err), 32'd1);
        bus_busy = 1'b0;
        tick();
        chk("bto_errpulse", 32'(timeout_err), 32'd0);
        tick();
        chk_grant("bto_next", 6'b001000, 3'd3);

        // Abandon by master 1 updates the pointer to 1
        bus_req = 6'b000000;
        tick();
        tick();
        bus_req = 6'b000010;
        tick();
        chk_grant("ab1_grant", 6'b000010, 3'd1);
        bus_req = 6'b000000;
        tick();
        chk_grant("ab1_rel", 6'b000000, 3'd1);
        chk("ab1_terr", 32'(timeout_err), 32'd0);
        bus_req = 6'b000110;
        tick();
        tick();
        chk_grant("ab1_last", 6'b000100, 3'd2);

        // Reset mid-tenure returns priority to master 0
        bus_busy = 1'b1;
        tick();
        chk("midrst_busy", 32'(bus_grant), 32'(6'b000100));
        reset_n = 1'b0;
        tick();
        chk_grant("midrst", 6'b000000, 3'd0);
        chk("midrst_terr", 32'(timeout_err), 32'd0);
        reset_n  = 1'b1;
        bus_busy = 1'b0;
        bus_req  = 6'b100001;
        tick();
        chk_grant("midrst_prio", 6'b000001, 3'd0);

        // Busy rising with request drop in GRANT goes to BUSY
        bus_busy = 1'b1;
        bus_req  = 6'b000000;
        tick();
        chk("simul_busy", 32'(bus_grant), 32'(6'b000001));
        bus_busy = 1'b0;
        tick();
        chk("simul_rel", 32'(bus_grant), 32'd0);
        chk("simul_terr", 32'(timeout_err), 32'd0);

        // Busy falling exactly at the last counter value is a normal release
        bus_req = 6'b000010;
        tick();
        tick();
        chk_grant("edge_grant", 6'b000010, 3'd1);
        bus_busy = 1'b1;
        tick(); tick(); tick(); tick();
        chk("edge_hold", 32'(bus_grant), 32'(6'b000010));
        bus_busy = 1'b0;
        tick();
        chk("edge_rel", 32'(bus_grant), 32'd0);
        chk("edge_terr", 32'(timeout_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
